// File: rtl/baud_pkg.sv
// baud_pkg: rate table and elaboration-time divisor helpers for baud_tick_generator.
// Fractional divisor support is selected with the BAUD_FRAC_EN macro.
package baud_pkg;

    localparam int unsigned NUM_RATES      = 8;
    localparam int unsigned SEL_W          = 3;
    localparam int unsigned OVERSAMPLE_DEF = 16;

    // Baud rates addressed by baud_select 0..7
    localparam int unsigned BAUD_RATES [NUM_RATES] = '{
        32'd300, 32'd1200, 32'd4800, 32'd9600,
        32'd19200, 32'd38400, 32'd57600, 32'd115200
    };

    // Divisor clk_hz / (rate * os) rounded to the nearest integer
    function automatic longint unsigned div_round(input longint unsigned clk_hz,
                                                  input longint unsigned rate,
                                                  input longint unsigned os);
        longint unsigned den;
        den = rate * os;
        return (64'd2 * clk_hz + den) / (64'd2 * den);
    endfunction

    // Fractional part of the divisor in 2^frac_w units, rounded (may reach 2^frac_w)
    function automatic longint unsigned frac_raw(input longint unsigned clk_hz,
                                                 input longint unsigned rate,
                                                 input longint unsigned os,
                                                 input longint unsigned frac_w);
        longint unsigned den;
        longint unsigned rem;
        den = rate * os;
        rem = clk_hz % den;
        return ((rem << (frac_w + 64'd1)) + den) / (64'd2 * den);
    endfunction

    // Integer part of the divisor, absorbing a fraction that rounded up to one
    function automatic longint unsigned div_floor(input longint unsigned clk_hz,
                                                  input longint unsigned rate,
                                                  input longint unsigned os,
                                                  input longint unsigned frac_w);
        return (clk_hz / (rate * os)) + (frac_raw(clk_hz, rate, os, frac_w) >> frac_w);
    endfunction

    // Fractional increment added to the accumulator on every sample tick
    function automatic longint unsigned div_frac(input longint unsigned clk_hz,
                                                 input longint unsigned rate,
                                                 input longint unsigned os,
                                                 input longint unsigned frac_w);
        return frac_raw(clk_hz, rate, os, frac_w) & ((64'd1 << frac_w) - 64'd1);
    endfunction

    // Width of the oversample phase counter
    function automatic int unsigned cnt_width(input int unsigned os);
        return (os < 32'd2) ? 32'd1 : 32'($clog2(os));
    endfunction

endpackage

// File: rtl/baud_divider.sv
// baud_divider: programmable period counter emitting a one-clock raw tick.
// With BAUD_FRAC_EN defined, a fractional accumulator stretches one period by a
// clock on every accumulator carry.
module baud_divider #(
    parameter int unsigned DIV_W  = 16
`ifdef BAUD_FRAC_EN
    ,
    parameter int unsigned FRAC_W = 8
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic [DIV_W-1:0]  limit,
`ifdef BAUD_FRAC_EN
    input  logic [FRAC_W-1:0] frac,
`endif
    output logic              tick_c
);

    logic [DIV_W-1:0]  cnt_q;
    logic [DIV_W-1:0]  cnt_d;
    logic              expire;
`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] acc_q;
    logic [FRAC_W-1:0] acc_d;
    logic              ext_q;
    logic              ext_d;
`endif

    // Terminal count: the period ends after limit+1 clocks (one more after a carry)
    always_comb begin
`ifdef BAUD_FRAC_EN
        expire = ({1'b0, cnt_q} >= ({1'b0, limit} + (DIV_W+1)'(ext_q)));
`else
        expire = (cnt_q >= limit);
`endif
    end

    // Count, restart on clear, hold while disabled
    always_comb begin
        cnt_d  = cnt_q;
        tick_c = 1'b0;
`ifdef BAUD_FRAC_EN
        acc_d  = acc_q;
        ext_d  = ext_q;
`endif
        if (clear) begin
            cnt_d = '0;
`ifdef BAUD_FRAC_EN
            acc_d = '0;
            ext_d = 1'b0;
`endif
        end else if (enable) begin
            if (expire) begin
                cnt_d  = '0;
                tick_c = 1'b1;
`ifdef BAUD_FRAC_EN
                {ext_d, acc_d} = {1'b0, acc_q} + {1'b0, frac};
`endif
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    // Divider state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
`ifdef BAUD_FRAC_EN
            acc_q <= '0;
            ext_q <= 1'b0;
`endif
        end else begin
            cnt_q <= cnt_d;
`ifdef BAUD_FRAC_EN
            acc_q <= acc_d;
            ext_q <= ext_d;
`endif
        end
    end

endmodule

// File: rtl/baud_tick_generator.sv
// baud_tick_generator: UART oversample / bit / mid-bit tick generator with a
// runtime-selectable rate table. Define BAUD_FRAC_EN for fractional divisors.
module baud_tick_generator
    import baud_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FRAC_W     = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [SEL_W-1:0]                    baud_select,
    input  logic                                enable,
    input  logic                                restart,
    output logic                                sample_tick,
    output logic                                bit_tick,
    output logic                                mid_tick,
    output logic [cnt_width(OVERSAMPLE)-1:0]    sample_count
);

    localparam int unsigned CNT_W = cnt_width(OVERSAMPLE);

    if ((OVERSAMPLE < 4) || (OVERSAMPLE > 64) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_os
        $error("baud_tick_generator: OVERSAMPLE must be even and within 4..64");
    end
    if ((FRAC_W < 1) || (FRAC_W > 32)) begin : g_bad_frac_w
        $error("baud_tick_generator: FRAC_W must be within 1..32");
    end

    logic [DIV_W-1:0]  limit_tbl [NUM_RATES];
`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] frac_tbl  [NUM_RATES];
`endif

    // Divisor table, fixed at elaboration; out-of-range divisors stop the build
    for (genvar i = 0; i < NUM_RATES; i++) begin : g_tbl
`ifdef BAUD_FRAC_EN
        localparam longint unsigned DIV = div_floor(64'(CLK_HZ), 64'(BAUD_RATES[i]),
                                                    64'(OVERSAMPLE), 64'(FRAC_W));
        localparam longint unsigned FRC = div_frac(64'(CLK_HZ), 64'(BAUD_RATES[i]),
                                                   64'(OVERSAMPLE), 64'(FRAC_W));
        assign frac_tbl[i] = FRAC_W'(FRC);
`else
        localparam longint unsigned DIV = div_round(64'(CLK_HZ), 64'(BAUD_RATES[i]),
                                                    64'(OVERSAMPLE));
`endif
        if ((DIV < 64'd2) || (DIV >= (64'd1 << DIV_W))) begin : g_bad_div
            $error("baud_tick_generator: divisor for rate index %0d out of range", i);
        end
        assign limit_tbl[i] = DIV_W'(DIV - 64'd1);
    end

    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_d;
    logic             sel_valid_q;
    logic             sel_valid_d;
    logic [SEL_W-1:0] sel_idx_c;
    logic             change_c;
    logic             clear_c;
    logic             tick_c;

    logic [CNT_W-1:0] sample_count_q;
    logic [CNT_W-1:0] sample_count_d;
    logic             sample_tick_q;
    logic             sample_tick_d;
    logic             bit_tick_q;
    logic             bit_tick_d;
    logic             mid_tick_q;
    logic             mid_tick_d;

    // Rate tracking: first clock after reset adopts baud_select, later changes resync
    always_comb begin
        sel_d       = baud_select;
        sel_valid_d = 1'b1;
        change_c    = sel_valid_q && (baud_select != sel_q);
        clear_c     = restart || change_c;
        sel_idx_c   = sel_valid_q ? sel_q : baud_select;
    end

    baud_divider #(
        .DIV_W  (DIV_W)
`ifdef BAUD_FRAC_EN
        ,
        .FRAC_W (FRAC_W)
`endif
    ) u_divider (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clear  (clear_c),
        .limit  (limit_tbl[sel_idx_c]),
`ifdef BAUD_FRAC_EN
        .frac   (frac_tbl[sel_idx_c]),
`endif
        .tick_c (tick_c)
    );

    // Oversample phase counter and tick decode
    always_comb begin
        sample_count_d = sample_count_q;
        sample_tick_d  = tick_c;
        bit_tick_d     = tick_c && (sample_count_q == CNT_W'(OVERSAMPLE - 1));
        mid_tick_d     = tick_c && (sample_count_q == CNT_W'(OVERSAMPLE / 2 - 1));
        if (clear_c) begin
            sample_count_d = '0;
        end else if (tick_c) begin
            sample_count_d = (sample_count_q == CNT_W'(OVERSAMPLE - 1))
                           ? '0 : sample_count_q + CNT_W'(1);
        end
    end

    // Output and tracking registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q          <= '0;
            sel_valid_q    <= 1'b0;
            sample_count_q <= '0;
            sample_tick_q  <= 1'b0;
            bit_tick_q     <= 1'b0;
            mid_tick_q     <= 1'b0;
        end else begin
            sel_q          <= sel_d;
            sel_valid_q    <= sel_valid_d;
            sample_count_q <= sample_count_d;
            sample_tick_q  <= sample_tick_d;
            bit_tick_q     <= bit_tick_d;
            mid_tick_q     <= mid_tick_d;
        end
    end

    assign sample_tick  = sample_tick_q;
    assign bit_tick     = bit_tick_q;
    assign mid_tick     = mid_tick_q;
    assign sample_count = sample_count_q;

endmodule

// File: tb/tb_baud_tick_generator.sv
// tb_baud_tick_generator: directed and randomized checks of baud_tick_generator
// against an arithmetic tick-time model. Honours BAUD_FRAC_EN like the design.
module tb_baud_tick_generator;

    localparam int unsigned CLK_HZ = 50_000_000;
    localparam int unsigned OS     = 16;
    localparam int unsigned CNT_W  = $clog2(OS);
    localparam int unsigned FW     = 8;
    localparam longint      OSL    = 64'(OS);

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       baud_select;
    logic             enable;
    logic             restart;
    logic             sample_tick;
    logic             bit_tick;
    logic             mid_tick;
    logic [CNT_W-1:0] sample_count;

    int checks = 0;
    int errors = 0;

    int unsigned rates [8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};
    longint d_int  [8];
    longint d_frac [8];

    // Model: enabled clocks and ticks since the last resync
    longint m_k;
    longint m_n;
    int     m_sel;
    logic   m_valid;
    logic   e_tick;
    logic   e_bit;
    logic   e_mid;

    baud_tick_generator #(
        .CLK_HZ     (CLK_HZ),
        .OVERSAMPLE (OS),
        .DIV_W      (16),
        .FRAC_W     (FW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .baud_select  (baud_select),
        .enable       (enable),
        .restart      (restart),
        .sample_tick  (sample_tick),
        .bit_tick     (bit_tick),
        .mid_tick     (mid_tick),
        .sample_count (sample_count)
    );

    always #5 clk = ~clk;

    // Clock count at which the n-th sample tick after a resync fires (n >= 1)
    function automatic longint t_of(input int sel, input longint n);
`ifdef BAUD_FRAC_EN
        return n * d_int[sel] + (((n - 1) * d_frac[sel]) >> FW);
`else
        return n * d_int[sel];
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: advance the model on the edge, compare outputs just after it
    task automatic step();
        logic chg;
        @(posedge clk);
        e_tick = 1'b0;
        e_bit  = 1'b0;
        e_mid  = 1'b0;
        if (reset) begin
            m_valid = 1'b0;
            m_k     = 0;
            m_n     = 0;
        end else begin
            chg     = m_valid && (m_sel != 32'(baud_select));
            m_sel   = 32'(baud_select);
            m_valid = 1'b1;
            if (restart || chg) begin
                m_k = 0;
                m_n = 0;
            end else if (enable) begin
                m_k++;
                if (m_k == t_of(m_sel, m_n + 1)) begin
                    e_tick = 1'b1;
                    e_bit  = ((m_n % OSL) == OSL - 1);
                    e_mid  = ((m_n % OSL) == OSL / 2 - 1);
                    m_n++;
                end
            end
        end
        #1;
        check("sample_tick", 64'(sample_tick), 64'(e_tick));
        check("bit_tick", 64'(bit_tick), 64'(e_bit));
        check("mid_tick", 64'(mid_tick), 64'(e_mid));
        check("sample_count", 64'(sample_count), 64'(m_n % OSL));
    endtask

    // Step until the chosen output pulses (0 sample, 1 bit, 2 mid); cyc = clocks taken
    task automatic wait_for(input int which, input int budget, output int cyc);
        logic seen;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && (cyc < budget)) begin
            step();
            cyc++;
            case (which)
                0:       seen = sample_tick;
                1:       seen = bit_tick;
                default: seen = mid_tick;
            endcase
        end
        check("wait_seen", 64'(seen), 64'(1));
    endtask

    initial begin
        int   c;
        int   guard;
        int   ticks;
        logic [CNT_W-1:0] frozen;
        real  d;

        for (int i = 0; i < 8; i++) begin
            d = real'(CLK_HZ) / (real'(rates[i]) * real'(OS));
`ifdef BAUD_FRAC_EN
            d_int[i]  = longint'($floor(d));
            d_frac[i] = longint'($floor((d - $floor(d)) * (2.0 ** FW) + 0.5));
`else
            d_int[i]  = longint'($floor(d + 0.5));
            d_frac[i] = 0;
`endif
        end
        m_k = 0; m_n = 0; m_sel = 0; m_valid = 1'b0;

        // Power-on reset at 115200 baud
        reset = 1'b1; baud_select = 3'd7; enable = 1'b1; restart = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        wait_for(0, 100, c);
        check("first_tick_sel7", 64'(c), 64'(t_of(7, 1)));
        wait_for(0, 100, c);
        check("sample_period", 64'(c), 64'(t_of(7, m_n) - t_of(7, m_n - 1)));
        wait_for(1, 1000, c);
        wait_for(1, 1000, c);
        check("bit_period", 64'(c), 64'(t_of(7, m_n) - t_of(7, m_n - OSL)));
        wait_for(2, 1000, c);
        check("mid_after_bit", 64'(c), 64'(t_of(7, m_n) - t_of(7, m_n - OSL / 2)));

        // Restart at phase 9, part way through a divider period
        guard = 0;
        while ((sample_count != CNT_W'(9)) && (guard < 1000)) begin
            step();
            guard++;
        end
        check("reach_phase9", 64'(sample_count), 64'(9));
        repeat (5) step();
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("restart_clears_count", 64'(sample_count), 64'(0));
        wait_for(0, 100, c);
        check("restart_latency", 64'(c), 64'(t_of(7, 1)));

        // Restart on the very edge a tick would fire
        repeat (int'(t_of(7, 2) - t_of(7, 1)) - 1) step();
        restart = 1'b1;
        step();
        restart = 1'b0;
        check("restart_suppresses_tick", 64'(sample_tick), 64'(0));
        wait_for(0, 100, c);
        check("restart_tick_latency", 64'(c), 64'(t_of(7, 1)));

        // Rate change 115200 -> 9600 mid-bit, then a 100-clock enable gap
        repeat (100) step();
        baud_select = 3'd3;
        step();
        check("rate_change_clears_count", 64'(sample_count), 64'(0));
        wait_for(0, 1000, c);
        check("new_rate_latency", 64'(c), 64'(t_of(3, 1)));
        repeat (50) step();
        enable = 1'b0;
        frozen = sample_count;
        ticks  = 0;
        repeat (100) begin
            step();
            ticks += int'(sample_tick) + int'(bit_tick) + int'(mid_tick);
        end
        check("no_ticks_disabled", 64'(ticks), 64'(0));
        check("count_frozen", 64'(sample_count), 64'(frozen));
        enable = 1'b1;
        wait_for(0, 1000, c);
        check("resume_latency", 64'(c), 64'(t_of(3, 2) - t_of(3, 1) - 50));

        // 300 baud from reset
        reset = 1'b1;
        baud_select = 3'd0;
        repeat (2) step();
        reset = 1'b0;
        wait_for(0, 11000, c);
        check("first_tick_sel0", 64'(c), 64'(t_of(0, 1)));

        // Asynchronous reset while a mid-bit tick is on the outputs
        reset = 1'b1;
        baud_select = 3'd7;
        step();
        reset = 1'b0;
        wait_for(2, 1000, c);
        reset = 1'b1;
        #1;
        check("async_rst_sample_tick", 64'(sample_tick), 64'(0));
        check("async_rst_mid_tick", 64'(mid_tick), 64'(0));
        check("async_rst_bit_tick", 64'(bit_tick), 64'(0));
        check("async_rst_count", 64'(sample_count), 64'(0));
        repeat (3) step();
        reset = 1'b0;
        wait_for(0, 100, c);
        check("post_reset_first_tick", 64'(c), 64'(t_of(7, 1)));
        wait_for(1, 1000, c);
        check("post_reset_first_bit", 64'(c), 64'(t_of(7, OSL) - t_of(7, 1)));

        // Randomized enable / restart / rate / reset activity
        for (int i = 0; i < 4000; i++) begin
            restart = ($urandom_range(96, 0) == 0);
            if ($urandom_range(49, 0) == 0) enable = ~enable;
            if ($urandom_range(599, 0) == 0) baud_select = 3'($urandom_range(7, 4));
            if (reset) reset = 1'b0;
            else if ($urandom_range(1499, 0) == 0) reset = 1'b1;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
